// File: rtl/async_fifo_ptr_ctrl.sv
// Per-domain pointer controller for a dual-clock FIFO: own pointer, Gray export, synchronised peer pointer, registered level/flags.
// Accepted inc shows after one edge, a peer pointer change after SYNC_STAGES+1 edges; inc is refused when full (write) or empty (read).
module async_fifo_ptr_ctrl #(
  parameter int PTR_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int SIDE        = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear_err,
  input  logic [PTR_W:0]   other_ptr_gray,
  input  logic [PTR_W:0]   afull_thresh,
  input  logic [PTR_W:0]   aempty_thresh,
  output logic [PTR_W-1:0] mem_addr,
  output logic [PTR_W:0]   ptr_gray,
  output logic [PTR_W:0]   level,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [PTR_W:0] DEPTH = {1'b1, {PTR_W{1'b0}}};

  logic [PTR_W:0] ptr;
  logic [PTR_W:0] next_ptr;
  logic [PTR_W:0] next_level;
  logic [PTR_W:0] other_bin;
  logic [PTR_W:0] sync_q [SYNC_STAGES];
  logic           reject;
  logic           acc;

  always_comb begin
    reject   = inc & ((SIDE == 0) ? full : empty);
    acc      = inc & ~reject;
    next_ptr = ptr + {{PTR_W{1'b0}}, acc};
    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    for (int i = 0; i <= PTR_W; i++) begin
      other_bin[i] = ^(sync_q[SYNC_STAGES-1] >> i);
    end
    next_level = (SIDE == 0) ? (next_ptr - other_bin) : (other_bin - next_ptr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= other_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr          <= '0;
      ptr_gray     <= '0;
      level        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      ptr          <= next_ptr;
      ptr_gray     <= next_ptr ^ (next_ptr >> 1);
      level        <= next_level;
      full         <= (next_level == DEPTH);
      empty        <= (next_level == '0);
      almost_full  <= (next_level >= afull_thresh);
      almost_empty <= (next_level <= aempty_thresh);
      // A new error outranks a simultaneous clear.
      if ((SIDE == 0) && reject) begin
        overflow <= 1'b1;
      end else if (clear_err) begin
        overflow <= 1'b0;
      end
      if ((SIDE == 1) && reject) begin
        underflow <= 1'b1;
      end else if (clear_err) begin
        underflow <= 1'b0;
      end
    end
  end

  assign mem_addr = ptr[PTR_W-1:0];

endmodule

// File: tb/tb_async_fifo_ptr_ctrl.sv
// Bench: a write-side and a read-side instance (PTR_W=3) driven side by side; a count-based model
// feeds per-side expectation queues that a negedge monitor drains and compares.
module tb_async_fifo_ptr_ctrl;

  localparam int SYNC = 2;

  typedef struct packed {
    logic [2:0] addr;
    logic [3:0] gray;
    logic [3:0] lvl;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       err;
    logic       xerr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       w_inc = 1'b0, w_clr = 1'b0;
  logic [3:0] w_oth = '0, w_af = 4'd8, w_ae = '0;
  logic [3:0] w_opg;
  logic [2:0] w_mem_addr;
  logic [3:0] w_ptr_gray, w_level;
  logic       w_full, w_empty, w_almost_full, w_almost_empty, w_overflow, w_underflow;

  logic       r_inc = 1'b0, r_clr = 1'b0;
  logic [3:0] r_oth = '0, r_af = 4'd8, r_ae = '0;
  logic [3:0] r_opg;
  logic [2:0] r_mem_addr;
  logic [3:0] r_ptr_gray, r_level;
  logic       r_full, r_empty, r_almost_full, r_almost_empty, r_overflow, r_underflow;

  assign w_opg = w_oth ^ (w_oth >> 1);
  assign r_opg = r_oth ^ (r_oth >> 1);

  always #5 clk = ~clk;

  async_fifo_ptr_ctrl #(.PTR_W(3), .SYNC_STAGES(SYNC), .SIDE(0)) u_w (
    .clk(clk), .reset(reset), .inc(w_inc), .clear_err(w_clr),
    .other_ptr_gray(w_opg), .afull_thresh(w_af), .aempty_thresh(w_ae),
    .mem_addr(w_mem_addr), .ptr_gray(w_ptr_gray), .level(w_level),
    .full(w_full), .empty(w_empty), .almost_full(w_almost_full), .almost_empty(w_almost_empty),
    .overflow(w_overflow), .underflow(w_underflow)
  );

  async_fifo_ptr_ctrl #(.PTR_W(3), .SYNC_STAGES(SYNC), .SIDE(1)) u_r (
    .clk(clk), .reset(reset), .inc(r_inc), .clear_err(r_clr),
    .other_ptr_gray(r_opg), .afull_thresh(r_af), .aempty_thresh(r_ae),
    .mem_addr(r_mem_addr), .ptr_gray(r_ptr_gray), .level(r_level),
    .full(r_full), .empty(r_empty), .almost_full(r_almost_full), .almost_empty(r_almost_empty),
    .overflow(r_overflow), .underflow(r_underflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: total accepted operations per side, and the peer pointer history seen through the synchroniser.
  int   own [2];
  int   hist [2][SYNC];
  logic m_full [2], m_empty [2], m_err [2];
  exp_t wq[$], rq[$];

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      own[s] = 0;
      for (int k = 0; k < SYNC; k++) hist[s][k] = 0;
      m_full[s] = 1'b0;
      m_empty[s] = 1'b1;
      m_err[s] = 1'b0;
    end
  endtask

  task automatic model_step(input int s, input logic inc, input logic clr, input int oth,
                            input int af, input int ae, output exp_t e);
    int   seen, lvl, p;
    logic rej;
    rej = inc && ((s == 0) ? m_full[s] : m_empty[s]);
    if (inc && !rej) own[s]++;
    seen = hist[s][0];
    for (int k = 0; k < SYNC - 1; k++) hist[s][k] = hist[s][k+1];
    hist[s][SYNC-1] = oth;
    lvl = (s == 0) ? (own[s] - seen) : (seen - own[s]);
    lvl = ((lvl % 16) + 16) % 16;
    m_full[s]  = (lvl == 8);
    m_empty[s] = (lvl == 0);
    if (rej) m_err[s] = 1'b1;
    else if (clr) m_err[s] = 1'b0;
    p = own[s] % 16;
    e.addr  = 3'(own[s] % 8);
    e.gray  = 4'(p ^ (p >> 1));
    e.lvl   = 4'(lvl);
    e.full  = m_full[s];
    e.empty = m_empty[s];
    e.af    = (lvl >= af);
    e.ae    = (lvl <= ae);
    e.err   = m_err[s];
    e.xerr  = 1'b0;
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    model_step(0, w_inc, w_clr, int'(w_oth), int'(w_af), int'(w_ae), e);
    wq.push_back(e);
    model_step(1, r_inc, r_clr, int'(r_oth), int'(r_af), int'(r_ae), e);
    rq.push_back(e);
  endtask

  task automatic do_reset();
    exp_t e;
    reset = 1'b1;
    wq.delete();
    rq.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    e = '{addr: 3'd0, gray: 4'd0, lvl: 4'd0, full: 1'b0, empty: 1'b1, af: 1'b0, ae: 1'b1, err: 1'b0, xerr: 1'b0};
    wq.push_back(e);
    rq.push_back(e);
  endtask

  logic [3:0] pw = '0, pr = '0;

  always @(negedge clk) begin
    exp_t e, a;
    if (reset) begin
      pw = '0;
      pr = '0;
    end else begin
      if (wq.size() > 0) begin
        e = wq.pop_front();
        a = {w_mem_addr, w_ptr_gray, w_level, w_full, w_empty, w_almost_full, w_almost_empty, w_overflow, w_underflow};
        check("w_state", 32'(a), 32'(e));
      end
      if (rq.size() > 0) begin
        e = rq.pop_front();
        a = {r_mem_addr, r_ptr_gray, r_level, r_full, r_empty, r_almost_full, r_almost_empty, r_underflow, r_overflow};
        check("r_state", 32'(a), 32'(e));
      end
      check("w_gray_one_bit", 32'($countones(pw ^ w_ptr_gray) <= 1), 32'd1);
      check("r_gray_one_bit", 32'($countones(pr ^ r_ptr_gray) <= 1), 32'd1);
      pw = w_ptr_gray;
      pr = r_ptr_gray;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_total;
    model_reset();
    #2;
    do_reset();

    // Fill the write side to DEPTH, then one refused push.
    w_inc = 1'b1;
    repeat (8) step();
    check("fill_level", 32'(w_level), 32'd8);
    check("fill_full", 32'(w_full), 32'd1);
    check("fill_addr", 32'(w_mem_addr), 32'd0);
    check("fill_gray", 32'(w_ptr_gray), 32'b1100);
    step();
    check("ovf_addr", 32'(w_mem_addr), 32'd0);
    check("ovf_flag", 32'(w_overflow), 32'd1);

    // Reader has consumed 3: visible after SYNC+1 edges.
    w_inc = 1'b0;
    w_oth = 4'd3;
    step();
    step();
    check("lag_still_full", 32'(w_full), 32'd1);
    step();
    check("lag_level", 32'(w_level), 32'd5);
    check("lag_full", 32'(w_full), 32'd0);
    w_clr = 1'b1;
    step();
    w_clr = 1'b0;
    check("ovf_cleared", 32'(w_overflow), 32'd0);

    // Random push/pop with wraps, random thresholds and clears.
    do_reset();
    rd_total = 0;
    for (int i = 0; i < 200; i++) begin
      w_inc = ($urandom_range(0, 99) < 60);
      w_clr = ($urandom_range(0, 9) == 0);
      if (rd_total < own[0] && $urandom_range(0, 1) == 1) rd_total++;
      w_oth = 4'(rd_total % 16);
      w_af  = 4'($urandom_range(0, 9));
      w_ae  = 4'($urandom_range(0, 9));
      step();
    end
    check("wrapped", 32'(own[0] > 16 && rd_total > 16), 32'd1);
    w_inc = 1'b0;
    w_clr = 1'b0;
    w_af = 4'd8;
    w_ae = 4'd0;
    if (own[0] == rd_total) begin
      w_inc = 1'b1;
      step();
      w_inc = 1'b0;
    end

    // Reset mid-operation takes effect without a clock edge.
    reset = 1'b1;
    #1;
    check("mid_reset", 32'({w_level, w_ptr_gray, w_mem_addr, w_full, w_empty, w_almost_empty, w_overflow}),
          32'({4'd0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0}));
    w_oth = 4'd0;
    do_reset();

    // Read side: writer published 5 entries; 7 pops, 2 refused.
    r_oth = 4'd5;
    repeat (3) step();
    check("rd_level5", 32'(r_level), 32'd5);
    r_inc = 1'b1;
    repeat (5) step();
    check("rd_empty", 32'({r_empty, r_level, r_mem_addr}), 32'({1'b1, 4'd0, 3'd5}));
    check("rd_no_udf_yet", 32'(r_underflow), 32'd0);
    repeat (2) step();
    check("rd_udf", 32'(r_underflow), 32'd1);
    check("rd_addr_held", 32'(r_mem_addr), 32'd5);
    r_clr = 1'b1;
    step();
    check("rd_err_wins", 32'(r_underflow), 32'd1);
    r_inc = 1'b0;
    step();
    r_clr = 1'b0;
    check("rd_clr", 32'(r_underflow), 32'd0);

    // Thresholds on the write side.
    do_reset();
    w_af = 4'd6;
    w_ae = 4'd1;
    w_inc = 1'b1;
    step();
    check("ae_edge1", 32'(w_almost_empty), 32'd1);
    step();
    check("ae_edge2", 32'(w_almost_empty), 32'd0);
    repeat (3) step();
    check("af_edge5", 32'(w_almost_full), 32'd0);
    step();
    check("af_edge6", 32'({w_almost_full, w_level}), 32'({1'b1, 4'd6}));
    w_inc = 1'b0;
    w_af = 4'd7;
    step();
    check("af_raise_thresh", 32'(w_almost_full), 32'd0);
    w_af = 4'd0;
    step();
    check("af_zero_thresh", 32'(w_almost_full), 32'd1);
    w_ae = 4'd8;
    step();
    check("ae_depth_thresh", 32'(w_almost_empty), 32'd1);

    @(negedge clk);
    #1;
    check("queues_drained", 32'(wq.size() + rq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
